// File: rtl/tt_pkg.sv
// rtl/tt_pkg.sv - shared types, defaults and table lookup for the truth-table engine
package tt_pkg;

  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    LOAD  = 2'd1,
    SWEEP = 2'd2
  } tt_state_e;

  // Default function: output 1 for inputs 001 and 010 only
  localparam logic [7:0] TT_TABLE_INIT = 8'h60;

  // Widest table supported (N_IN up to 6)
  localparam int TT_MAX_W = 64;

  // Table is stored MSB-first: entry for input vector idx lives at bit w-1-idx
  function automatic logic tt_lookup(input logic [TT_MAX_W-1:0] tbl,
                                     input int w,
                                     input int idx);
    logic [5:0] pos;
    pos = 6'(w - 1 - idx);
    return tbl[pos];
  endfunction

endpackage

// File: rtl/tt_out_reg.sv
// rtl/tt_out_reg.sv - single-entry valid/ready output register carrying {bit, idx, last}
module tt_out_reg #(
  parameter int N_IN = 3
) (
  input  logic            clk,
  input  logic            reset,
  input  logic            load_i,
  input  logic            bit_i,
  input  logic [N_IN-1:0] idx_i,
  input  logic            last_i,
  input  logic            ready_i,
  output logic            free_o,
  output logic            valid_o,
  output logic            bit_o,
  output logic [N_IN-1:0] idx_o,
  output logic            last_o
);

  logic            valid_q;
  logic            bit_q;
  logic [N_IN-1:0] idx_q;
  logic            last_q;

  // Slot can take a new entry when empty or when the current one leaves this cycle
  assign free_o = !valid_q || ready_i;

  // Capture a new entry when loaded; otherwise hold until the consumer takes it
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      valid_q <= 1'b0;
      bit_q   <= 1'b0;
      idx_q   <= '0;
      last_q  <= 1'b0;
    end else if (load_i) begin
      valid_q <= 1'b1;
      bit_q   <= bit_i;
      idx_q   <= idx_i;
      last_q  <= last_i;
    end else if (ready_i) begin
      valid_q <= 1'b0;
    end
  end

  assign valid_o = valid_q;
  assign bit_o   = bit_q;
  assign idx_o   = idx_q;
  assign last_o  = last_q;

endmodule

// File: rtl/truth_table_engine.sv
// rtl/truth_table_engine.sv - runtime-loadable N-input truth table with eval, load and sweep
module truth_table_engine
  import tt_pkg::*;
#(
  parameter int                 N_IN       = 3,
  parameter int                 TABLE_W    = 2**N_IN,
  parameter logic [TABLE_W-1:0] TABLE_INIT = TABLE_W'(TT_TABLE_INIT)
) (
  input  logic               clk,
  input  logic               reset,
  input  logic [N_IN-1:0]    in_vec,
  input  logic               in_valid,
  output logic               in_ready,
  output logic               out_bit,
  output logic [N_IN-1:0]    out_idx,
  output logic               out_last,
  output logic               out_valid,
  input  logic               out_ready,
  input  logic               sweep_start,
  input  logic               cfg_start,
  input  logic               cfg_valid,
  input  logic               cfg_bit,
  output logic               cfg_done,
  output logic               busy,
  output logic [TABLE_W-1:0] table_q
);

  localparam logic [N_IN:0]   CNT_LAST = (N_IN+1)'(TABLE_W - 1);
  localparam logic [N_IN-1:0] IDX_LAST = N_IN'(TABLE_W - 1);

  tt_state_e          state_q;
  logic [TABLE_W-1:0] shadow_q;
  logic [TABLE_W-1:0] shadow_d;
  logic [N_IN:0]      cnt_q;
  logic [N_IN-1:0]    idx_q;

  logic               out_free;
  logic               out_load_d;
  logic               out_bit_d;
  logic [N_IN-1:0]    out_idx_d;
  logic               out_last_d;

  // Next shadow value: shift in from the LSB so the first bit ends at the MSB
  assign shadow_d = {shadow_q[TABLE_W-2:0], cfg_bit};

  // Accept evaluations only in IDLE with a free slot and no competing start request
  assign in_ready = !reset && (state_q == IDLE) && out_free && !cfg_start && !sweep_start;

  assign busy = (state_q != IDLE);

  // Select what goes into the output register this cycle
  always_comb begin
    out_load_d = 1'b0;
    out_bit_d  = 1'b0;
    out_idx_d  = '0;
    out_last_d = 1'b0;
    case (state_q)
      IDLE: begin
        if (in_valid && in_ready) begin
          out_load_d = 1'b1;
          out_bit_d  = tt_lookup(TT_MAX_W'(table_q), TABLE_W, int'(in_vec));
          out_idx_d  = in_vec;
        end
      end
      SWEEP: begin
        if (out_free) begin
          out_load_d = 1'b1;
          out_bit_d  = tt_lookup(TT_MAX_W'(table_q), TABLE_W, int'(idx_q));
          out_idx_d  = idx_q;
          out_last_d = (idx_q == IDX_LAST);
        end
      end
      default: ;
    endcase
  end

  // Control FSM plus table storage; table only ever changes as a whole word
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state_q  <= IDLE;
      table_q  <= TABLE_INIT;
      shadow_q <= '0;
      cnt_q    <= '0;
      idx_q    <= '0;
      cfg_done <= 1'b0;
    end else begin
      cfg_done <= 1'b0;
      case (state_q)
        IDLE: begin
          if (cfg_start) begin
            state_q  <= LOAD;
            shadow_q <= '0;
            cnt_q    <= '0;
          end else if (sweep_start) begin
            state_q <= SWEEP;
            idx_q   <= '0;
          end
        end
        LOAD: begin
          if (cfg_valid) begin
            shadow_q <= shadow_d;
            if (cnt_q == CNT_LAST) begin
              table_q  <= shadow_d;
              cfg_done <= 1'b1;
              cnt_q    <= '0;
              state_q  <= IDLE;
            end else begin
              cnt_q <= cnt_q + 1'b1;
            end
          end
        end
        SWEEP: begin
          if (out_free) begin
            if (idx_q == IDX_LAST) begin
              idx_q   <= '0;
              state_q <= IDLE;
            end else begin
              idx_q <= idx_q + 1'b1;
            end
          end
        end
        default: state_q <= IDLE;
      endcase
    end
  end

  tt_out_reg #(
    .N_IN (N_IN)
  ) u_out_reg (
    .clk     (clk),
    .reset   (reset),
    .load_i  (out_load_d),
    .bit_i   (out_bit_d),
    .idx_i   (out_idx_d),
    .last_i  (out_last_d),
    .ready_i (out_ready),
    .free_o  (out_free),
    .valid_o (out_valid),
    .bit_o   (out_bit),
    .idx_o   (out_idx),
    .last_o  (out_last)
  );

endmodule

// File: tb/tb_truth_table_engine.sv
// tb/tb_truth_table_engine.sv - scoreboard testbench for truth_table_engine
module tb_truth_table_engine;

  localparam int N_IN = 3;
  localparam int TW   = 8;

  logic            clk = 1'b0;
  logic            reset;
  logic [N_IN-1:0] in_vec;
  logic            in_valid;
  logic            in_ready;
  logic            out_bit;
  logic [N_IN-1:0] out_idx;
  logic            out_last;
  logic            out_valid;
  logic            out_ready;
  logic            sweep_start;
  logic            cfg_start;
  logic            cfg_valid;
  logic            cfg_bit;
  logic            cfg_done;
  logic            busy;
  logic [TW-1:0]   table_q;

  int checks = 0;
  int errors = 0;

  logic [TW-1:0] model_tbl;
  logic [4:0]    sb_q[$];

  truth_table_engine #(.N_IN(N_IN)) dut (
    .clk         (clk),
    .reset       (reset),
    .in_vec      (in_vec),
    .in_valid    (in_valid),
    .in_ready    (in_ready),
    .out_bit     (out_bit),
    .out_idx     (out_idx),
    .out_last    (out_last),
    .out_valid   (out_valid),
    .out_ready   (out_ready),
    .sweep_start (sweep_start),
    .cfg_start   (cfg_start),
    .cfg_valid   (cfg_valid),
    .cfg_bit     (cfg_bit),
    .cfg_done    (cfg_done),
    .busy        (busy),
    .table_q     (table_q)
  );

  always #5 clk = ~clk;

  // One clock: pop/compare any output transferred at the coming edge, then step past it
  task automatic cycle();
    logic [4:0] got;
    logic [4:0] exp;
    @(negedge clk);
    if (out_valid && out_ready) begin
      got = {out_bit, out_idx, out_last};
      checks++;
      if (sb_q.size() == 0) begin
        errors++;
        $display("FAIL sb_unexpected: got bit=%0b idx=%0d last=%0b, required no output", out_bit, out_idx, out_last);
      end else begin
        exp = sb_q.pop_front();
        if (got !== exp) begin
          errors++;
          $display("FAIL sb_entry: got bit=%0b idx=%0d last=%0b, required bit=%0b idx=%0d last=%0b",
                   got[4], got[3:1], got[0], exp[4], exp[3:1], exp[0]);
        end
      end
    end
    @(posedge clk);
    #1;
  endtask

  task automatic push_exp(input int idx, input logic last);
    logic [N_IN-1:0] i3;
    i3 = N_IN'(idx);
    sb_q.push_back({model_tbl[TW-1-idx], i3, last});
  endtask

  task automatic drain(input string name);
    int n;
    n = 0;
    while (sb_q.size() != 0 && n < 40) begin
      cycle();
      n++;
    end
    checks++;
    if (sb_q.size() != 0) begin
      errors++;
      $display("FAIL %s_drain_timeout: got %0d entries left, required 0", name, sb_q.size());
    end
  endtask

  task automatic test_reset();
    reset = 1'b1;
    @(posedge clk);
    #1;
    checks++;
    if ({out_valid, out_bit, out_idx, out_last, cfg_done, in_ready, busy} !== 9'b0) begin
      errors++;
      $display("FAIL reset_outputs: got valid=%0b bit=%0b idx=%0d last=%0b done=%0b rdy=%0b busy=%0b, required all 0",
               out_valid, out_bit, out_idx, out_last, cfg_done, in_ready, busy);
    end
    checks++;
    if (table_q !== 8'h60) begin
      errors++;
      $display("FAIL reset_table: got %h, required 60", table_q);
    end
    reset = 1'b0;
    model_tbl = 8'h60;
    cycle();
  endtask

  task automatic test_eval();
    int vecs[4];
    vecs = '{1, 3, 2, 7};
    for (int k = 0; k < 4; k++) begin
      in_vec   = N_IN'(vecs[k]);
      in_valid = 1'b1;
      #1;
      checks++;
      if (in_ready !== 1'b1) begin
        errors++;
        $display("FAIL eval_in_ready: got %0b, required 1", in_ready);
      end
      push_exp(vecs[k], 1'b0);
      cycle();
      if (k == 0) begin
        checks++;
        if (out_valid !== 1'b1 || out_bit !== 1'b1 || out_idx !== 3'd1) begin
          errors++;
          $display("FAIL eval_latency: got valid=%0b bit=%0b idx=%0d, required valid=1 bit=1 idx=1",
                   out_valid, out_bit, out_idx);
        end
      end
    end
    in_valid = 1'b0;
    drain("eval");
  endtask

  task automatic test_sweep(input string name);
    int n;
    sweep_start = 1'b1;
    for (int i = 0; i < TW; i++) push_exp(i, i == TW - 1);
    cycle();
    sweep_start = 1'b0;
    checks++;
    if (busy !== 1'b1) begin
      errors++;
      $display("FAIL %s_busy: got %0b, required 1", name, busy);
    end
    n = 0;
    while (sb_q.size() != 0 && n < 30) begin
      cycle();
      n++;
      if (out_valid && out_last) begin
        checks++;
        if (busy !== 1'b0) begin
          errors++;
          $display("FAIL %s_busy_at_last: got %0b, required 0", name, busy);
        end
      end
    end
    checks++;
    if (n != TW + 1) begin
      errors++;
      $display("FAIL %s_cycles: got %0d, required %0d", name, n, TW + 1);
    end
    checks++;
    if (busy !== 1'b0 || out_valid !== 1'b0) begin
      errors++;
      $display("FAIL %s_end: got busy=%0b valid=%0b, required 0 0", name, busy, out_valid);
    end
  endtask

  task automatic test_backpressure();
    int n;
    sweep_start = 1'b1;
    for (int i = 0; i < TW; i++) push_exp(i, i == TW - 1);
    cycle();
    sweep_start = 1'b0;
    n = 0;
    while (!(out_valid && out_idx == 3'd2) && n < 20) begin
      cycle();
      n++;
    end
    checks++;
    if (!(out_valid && out_idx == 3'd2)) begin
      errors++;
      $display("FAIL bp_reach_idx2: got valid=%0b idx=%0d, required valid=1 idx=2", out_valid, out_idx);
    end
    out_ready = 1'b0;
    repeat (3) begin
      cycle();
      checks++;
      if (out_valid !== 1'b1 || out_bit !== 1'b1 || out_idx !== 3'd2 || out_last !== 1'b0) begin
        errors++;
        $display("FAIL bp_hold: got valid=%0b bit=%0b idx=%0d last=%0b, required valid=1 bit=1 idx=2 last=0",
                 out_valid, out_bit, out_idx, out_last);
      end
    end
    out_ready = 1'b1;
    drain("bp");
    cycle();
    checks++;
    if (busy !== 1'b0) begin
      errors++;
      $display("FAIL bp_busy_end: got %0b, required 0", busy);
    end
  endtask

  task automatic test_load(input logic [TW-1:0] value, input int gap);
    int pulses;
    pulses = 0;
    cfg_start = 1'b1;
    cycle();
    cfg_start = 1'b0;
    checks++;
    if (busy !== 1'b1 || in_ready !== 1'b0) begin
      errors++;
      $display("FAIL load_enter: got busy=%0b rdy=%0b, required busy=1 rdy=0", busy, in_ready);
    end
    for (int i = 0; i < TW; i++) begin
      cfg_valid = 1'b1;
      cfg_bit   = value[TW-1-i];
      cycle();
      cfg_valid = 1'b0;
      if (cfg_done) pulses++;
      if (i < TW - 1) begin
        checks++;
        if (table_q !== model_tbl) begin
          errors++;
          $display("FAIL load_partial: got %h after bit %0d, required %h", table_q, i, model_tbl);
        end
        repeat (gap) begin
          cycle();
          if (cfg_done) pulses++;
        end
      end
    end
    checks++;
    if (table_q !== value || cfg_done !== 1'b1) begin
      errors++;
      $display("FAIL load_commit: got table=%h done=%0b, required table=%h done=1", table_q, cfg_done, value);
    end
    model_tbl = value;
    cycle();
    if (cfg_done) pulses++;
    checks++;
    if (pulses != 1) begin
      errors++;
      $display("FAIL load_done_pulses: got %0d, required 1", pulses);
    end
    checks++;
    if (busy !== 1'b0) begin
      errors++;
      $display("FAIL load_exit: got busy=%0b, required 0", busy);
    end
  endtask

  task automatic test_reset_midload();
    cfg_start = 1'b1;
    cycle();
    cfg_start = 1'b0;
    for (int i = 0; i < 4; i++) begin
      cfg_valid = 1'b1;
      cfg_bit   = 1'b1;
      cycle();
    end
    cfg_valid = 1'b0;
    reset = 1'b1;
    #1;
    checks++;
    if (table_q !== 8'h60 || busy !== 1'b0 || out_valid !== 1'b0 || in_ready !== 1'b0) begin
      errors++;
      $display("FAIL midload_reset: got table=%h busy=%0b valid=%0b rdy=%0b, required 60 0 0 0",
               table_q, busy, out_valid, in_ready);
    end
    @(posedge clk);
    #1;
    reset = 1'b0;
    model_tbl = 8'h60;
    sb_q.delete();
    in_vec   = 3'd1;
    in_valid = 1'b1;
    push_exp(1, 1'b0);
    cycle();
    in_valid = 1'b0;
    checks++;
    if (out_valid !== 1'b1 || out_bit !== 1'b1) begin
      errors++;
      $display("FAIL midload_eval: got valid=%0b bit=%0b, required 1 1", out_valid, out_bit);
    end
    drain("midload");
  endtask

  task automatic test_priority();
    logic [TW-1:0] v;
    v = 8'hA5;
    cfg_start   = 1'b1;
    sweep_start = 1'b1;
    in_valid    = 1'b1;
    in_vec      = 3'd1;
    #1;
    checks++;
    if (in_ready !== 1'b0) begin
      errors++;
      $display("FAIL prio_in_ready: got %0b, required 0", in_ready);
    end
    cycle();
    cfg_start   = 1'b0;
    sweep_start = 1'b0;
    in_valid    = 1'b0;
    checks++;
    if (busy !== 1'b1 || out_valid !== 1'b0) begin
      errors++;
      $display("FAIL prio_load_entered: got busy=%0b valid=%0b, required busy=1 valid=0", busy, out_valid);
    end
    for (int i = 0; i < TW; i++) begin
      cfg_valid = 1'b1;
      cfg_bit   = v[TW-1-i];
      cycle();
    end
    cfg_valid = 1'b0;
    checks++;
    if (table_q !== v || busy !== 1'b0) begin
      errors++;
      $display("FAIL prio_load_result: got table=%h busy=%0b, required table=%h busy=0", table_q, busy, v);
    end
    repeat (3) begin
      cycle();
      checks++;
      if (out_valid !== 1'b0 || busy !== 1'b0) begin
        errors++;
        $display("FAIL prio_no_sweep: got valid=%0b busy=%0b, required 0 0", out_valid, busy);
      end
    end
  endtask

  initial begin
    reset       = 1'b1;
    in_vec      = '0;
    in_valid    = 1'b0;
    out_ready   = 1'b1;
    sweep_start = 1'b0;
    cfg_start   = 1'b0;
    cfg_valid   = 1'b0;
    cfg_bit     = 1'b0;
    model_tbl   = 8'h60;

    test_reset();
    test_eval();
    test_sweep("sweep_default");
    test_backpressure();
    test_load(8'h96, 2);
    test_sweep("sweep_loaded");
    test_reset_midload();
    test_priority();

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
